// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART word transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [1:0] {
    IDLE,
    NEXT,
    SEND
  } state_t;

  localparam logic [31:0] DEFAULT_ID_WORD = 32'h534c4131;

  function automatic logic parity_bit(input logic [7:0] d, input parity_t mode);
    return (mode == PAR_ODD) ? ~(^d) : ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO with occupancy count; read data is the head entry.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered word transmitter: FIFO of masked words, serialised byte by byte as
// UART frames with optional parity, XON/XOFF pause and ID-word injection.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int          FREQ       = 100_000_000,
  parameter int          BAUD       = 921_600,
  parameter int          BIT_CYCLES = FREQ / BAUD,
  parameter int          NBYTES     = 4,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PARITY     = 0,
  parameter int          STOP_BITS  = 1,
  parameter logic [63:0] ID_WORD    = 64'(DEFAULT_ID_WORD)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [8*NBYTES-1:0]           wr_data,
  input  logic [NBYTES-1:0]             wr_mask,
  input  logic                          id_req,
  input  logic                          xon,
  input  logic                          xoff,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          uart_tx
);

  localparam int      DW    = 8 * NBYTES;
  localparam int      FW    = 9 * NBYTES;
  localparam int      NBITS = 10 + ((PARITY != 0) ? 1 : 0) + (STOP_BITS - 1);
  localparam int      IW    = $clog2(NBYTES + 1);
  localparam int      CW    = $clog2(BIT_CYCLES);
  localparam parity_t PMODE = parity_t'(2'(PARITY));

  state_t           state;
  logic             paused;
  logic             id_pending;
  logic             data_push;
  logic             id_push;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [FW-1:0]    push_data;
  logic [FW-1:0]    pop_data;
  logic [DW-1:0]    hold_data;
  logic [NBYTES-1:0] hold_mask;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    baud_cnt;
  logic [3:0]       bits_left;
  logic [11:0]      shift;
  logic [11:0]      frame;

  assign wr_ready  = !full;
  assign data_push = wr_valid && !full;
  assign id_push   = id_pending && !full && !data_push;
  assign push      = data_push || id_push;
  assign push_data = data_push ? {wr_mask, wr_data} : {{NBYTES{1'b0}}, ID_WORD[DW-1:0]};
  assign pop       = (state == IDLE) && !empty && !paused;
  assign busy      = (state != IDLE) || (fifo_level != '0) || paused || id_pending;

  uart_tx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paused     <= 1'b0;
      id_pending <= 1'b0;
    end else begin
      paused     <= xoff | (paused & ~xon);
      id_pending <= id_req | (id_pending & ~id_push);
    end
  end

  // Bits above NBITS stay 1, so the shifter can be a fixed 12 bits wide.
  always_comb begin
    frame      = '1;
    frame[0]   = 1'b0;
    frame[8:1] = hold_data[7:0];
    if (PMODE != PAR_NONE) frame[9] = parity_bit(hold_data[7:0], PMODE);
  end

  // The current byte is always hold_data[7:0] / hold_mask[0]; both shift down as idx advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_mask <= '0;
      idx       <= '0;
      baud_cnt  <= '0;
      bits_left <= '0;
      shift     <= '1;
      uart_tx   <= 1'b1;
    end else begin
      uart_tx <= shift[0];
      case (state)
        IDLE: begin
          if (pop) begin
            {hold_mask, hold_data} <= pop_data;
            idx   <= '0;
            state <= NEXT;
          end
        end
        NEXT: begin
          if (idx == IW'(NBYTES)) begin
            state <= IDLE;
          end else if (hold_mask[0] || !paused) begin
            idx       <= idx + IW'(1);
            hold_data <= hold_data >> 8;
            hold_mask <= hold_mask >> 1;
            if (!hold_mask[0]) begin
              shift     <= frame;
              baud_cnt  <= CW'(BIT_CYCLES - 1);
              bits_left <= 4'(NBITS - 1);
              state     <= SEND;
            end
          end
        end
        SEND: begin
          if (baud_cnt == '0) begin
            baud_cnt <= CW'(BIT_CYCLES - 1);
            if (bits_left == '0) begin
              shift <= '1;
              state <= NEXT;
            end else begin
              shift     <= {1'b1, shift[11:1]};
              bits_left <= bits_left - 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
